// File: rtl/gps_ack_sched.sv
// rtl/gps_ack_sched.sv - PRN sweep scheduler for the acquisition engine
module gps_ack_sched #(
  parameter int SAT_FIRST = 1,
  parameter int SAT_LAST  = 32,
  parameter int INT_W     = 14,
  parameter int THRESH    = 600,
  parameter int TIMEOUT   = 4000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             abort,
  output logic             busy,
  output logic             sweep_done,
  output logic             timeout_err,
  output logic             ack_start,
  output logic [5:0]       sat_sel,
  input  logic             corr_complete,
  input  logic [INT_W-1:0] integrator,
  input  logic [9:0]       code_phase,
  input  logic [15:0]      doppler_omega,
  input  logic             search_complete,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [5:0]       res_sat,
  output logic [INT_W-1:0] res_peak,
  output logic [9:0]       res_code_phase,
  output logic [15:0]      res_doppler,
  output logic             res_found
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [5:0]       FIRST   = 6'(SAT_FIRST);
  localparam logic [5:0]       LAST    = 6'(SAT_LAST);
  localparam logic [INT_W-1:0] THR     = INT_W'(THRESH);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REPORT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [INT_W-1:0] best_peak;
  logic [9:0]       best_code;
  logic [15:0]      best_dopp;
  logic [CNT_W-1:0] cnt;

  logic             capture;
  logic [INT_W-1:0] peak_n;
  logic [9:0]       code_n;
  logic [15:0]      dopp_n;
  logic [CNT_W-1:0] cnt_inc;

  // Best-so-far including the bin presented this cycle; strict compare keeps the earlier bin on ties
  always_comb begin
    capture = corr_complete && (integrator > best_peak);
    peak_n  = capture ? integrator    : best_peak;
    code_n  = capture ? code_phase    : best_code;
    dopp_n  = capture ? doppler_omega : best_dopp;
    cnt_inc = cnt + 1'b1;
  end

  // Sweep FSM with all outputs registered; abort overrides every state and any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      sweep_done     <= 1'b0;
      timeout_err    <= 1'b0;
      ack_start      <= 1'b0;
      sat_sel        <= FIRST;
      res_valid      <= 1'b0;
      res_sat        <= '0;
      res_peak       <= '0;
      res_code_phase <= '0;
      res_doppler    <= '0;
      res_found      <= 1'b0;
      best_peak      <= '0;
      best_code      <= '0;
      best_dopp      <= '0;
      cnt            <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      ack_start  <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state       <= S_START;
            sat_sel     <= FIRST;
            timeout_err <= 1'b0;
            ack_start   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_START: begin
          ack_start <= 1'b0;
          best_peak <= '0;
          best_code <= '0;
          best_dopp <= '0;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          best_peak <= peak_n;
          best_code <= code_n;
          best_dopp <= dopp_n;
          cnt       <= cnt_inc;
          if (search_complete) begin
            state          <= S_REPORT;
            res_valid      <= 1'b1;
            res_sat        <= sat_sel;
            res_peak       <= peak_n;
            res_code_phase <= code_n;
            res_doppler    <= dopp_n;
            res_found      <= (peak_n >= THR);
          end else if (cnt_inc == TO_LAST) begin
            // Engine never closed this PRN: report what we have, never as a detection
            state          <= S_REPORT;
            timeout_err    <= 1'b1;
            res_valid      <= 1'b1;
            res_sat        <= sat_sel;
            res_peak       <= peak_n;
            res_code_phase <= code_n;
            res_doppler    <= dopp_n;
            res_found      <= 1'b0;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (sat_sel == LAST) begin
            state      <= S_DONE;
            sweep_done <= 1'b1;
          end else begin
            sat_sel   <= sat_sel + 6'd1;
            state     <= S_START;
            ack_start <= 1'b1;
          end
        end
        S_DONE: begin
          sweep_done <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_ack_sched.sv
// tb/tb_gps_ack_sched.sv - directed table-driven bench for gps_ack_sched
module tb_gps_ack_sched;

  logic        clk = 1'b0;
  logic        rst, run, abort;
  logic        busy, sweep_done, timeout_err, ack_start;
  logic [5:0]  sat_sel;
  logic        corr_complete, search_complete;
  logic [13:0] integrator;
  logic [9:0]  code_phase;
  logic [15:0] doppler_omega;
  logic        res_valid, res_ready, res_found;
  logic [5:0]  res_sat;
  logic [13:0] res_peak;
  logic [9:0]  res_code_phase;
  logic [15:0] res_doppler;

  gps_ack_sched #(
    .SAT_FIRST(1), .SAT_LAST(3), .INT_W(14), .THRESH(600), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort),
    .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err),
    .ack_start(ack_start), .sat_sel(sat_sel),
    .corr_complete(corr_complete), .integrator(integrator),
    .code_phase(code_phase), .doppler_omega(doppler_omega),
    .search_complete(search_complete),
    .res_valid(res_valid), .res_ready(res_ready), .res_sat(res_sat),
    .res_peak(res_peak), .res_code_phase(res_code_phase),
    .res_doppler(res_doppler), .res_found(res_found)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int valid_cyc = 0;

  // Event counters sampled on the inactive edge
  always @(negedge clk) begin
    if (ack_start)  ack_cnt++;
    if (sweep_done) done_cnt++;
    if (res_valid)  valid_cyc++;
  end

  typedef struct {
    logic [4:0][13:0] pk;
    logic [4:0][9:0]  cp;
    logic [4:0][15:0] dp;
    bit               sc_last;
    logic [13:0]      e_peak;
    logic [9:0]       e_cp;
    logic [15:0]      e_dp;
    bit               e_found;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int v, input int i, input int pk, input int cp, input int dp);
    tbl[v].pk[i] = pk[13:0];
    tbl[v].cp[i] = cp[9:0];
    tbl[v].dp[i] = dp[15:0];
  endtask

  task automatic set_exp(input int v, input bit sc, input int pk, input int cp, input int dp, input bit f);
    tbl[v].sc_last = sc;
    tbl[v].e_peak  = pk[13:0];
    tbl[v].e_cp    = cp[9:0];
    tbl[v].e_dp    = dp[15:0];
    tbl[v].e_found = f;
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    while (ack_start !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, ack_start, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (res_valid !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, res_valid, 1);
  endtask

  // Drive one PRN's bins from the table and check the resulting record
  task automatic run_prn(input int v, input int sat, input int hold, input bit pulse_run);
    logic [13:0] s_pk;
    logic [9:0]  s_cp;
    logic [15:0] s_dp;
    bit          stable;
    wait_ack($sformatf("v%0d_ack", v), 10);
    check($sformatf("v%0d_sat_sel", v), sat_sel, sat);
    tick();
    for (int i = 0; i < 5; i++) begin
      corr_complete   = 1'b1;
      integrator      = tbl[v].pk[i];
      code_phase      = tbl[v].cp[i];
      doppler_omega   = tbl[v].dp[i];
      search_complete = (i == 4) && tbl[v].sc_last;
      if (i == 0 && pulse_run) run = 1'b1;
      tick();
      run = 1'b0;
    end
    corr_complete   = 1'b0;
    search_complete = 1'b0;
    if (!tbl[v].sc_last) begin
      search_complete = 1'b1;
      tick();
      search_complete = 1'b0;
    end
    res_ready = (hold == 0);
    wait_valid($sformatf("v%0d_valid", v), 8);
    check($sformatf("v%0d_res_sat", v), res_sat, sat);
    check($sformatf("v%0d_peak", v), res_peak, tbl[v].e_peak);
    check($sformatf("v%0d_code", v), res_code_phase, tbl[v].e_cp);
    check($sformatf("v%0d_dopp", v), res_doppler, tbl[v].e_dp);
    check($sformatf("v%0d_found", v), res_found, tbl[v].e_found);
    if (hold > 0) begin
      s_pk = res_peak; s_cp = res_code_phase; s_dp = res_doppler;
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        corr_complete   = (k == 3);
        integrator      = 14'h3fff;
        search_complete = (k == 5);
        tick();
        if (res_valid !== 1'b1 || ack_start !== 1'b0 || res_peak !== s_pk ||
            res_code_phase !== s_cp || res_doppler !== s_dp)
          stable = 1'b0;
      end
      corr_complete   = 1'b0;
      search_complete = 1'b0;
      check("bp_stable", stable, 1);
      res_ready = 1'b1;
      tick();
      check("bp_valid_drop", res_valid, 0);
      check("bp_no_ack_in_next", ack_start, 0);
      tick();
      check("bp_ack_after", ack_start, 1);
    end else begin
      tick();
    end
  endtask

  task automatic do_sweep(input int base, input int hold0);
    int a0, d0, n;
    a0 = ack_cnt;
    d0 = done_cnt;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int p = 0; p < 3; p++) run_prn(base + p, p + 1, (p == 0) ? hold0 : 0, 1'b0);
    n = 0;
    while (sweep_done !== 1'b1 && n < 6) begin tick(); n++; end
    check("sweep_done", sweep_done, 1);
    tick();
    check("sweep_busy_low", busy, 0);
    check("sweep_acks", ack_cnt - a0, 3);
    check("sweep_dones", done_cnt - d0, 1);
  endtask

  initial begin
    int t, a0, d0, v0;

    set_bin(0,0,100,1,3);  set_bin(0,1,250,2,-7);   set_bin(0,2,50,3,0);   set_bin(0,3,299,4,12); set_bin(0,4,10,5,1);
    set_exp(0, 1'b0, 299, 4, 12, 1'b0);
    set_bin(1,0,120,100,5); set_bin(1,1,900,512,-40); set_bin(1,2,300,7,8); set_bin(1,3,899,8,9); set_bin(1,4,900,9,10);
    set_exp(1, 1'b0, 900, 512, -40, 1'b1);
    for (int i = 0; i < 5; i++) set_bin(2, i, 0, i + 1, i + 1);
    set_exp(2, 1'b1, 0, 0, 0, 1'b0);
    set_bin(3,0,700,10,-1); set_bin(3,1,700,20,-2); set_bin(3,2,100,30,3); set_bin(3,3,699,40,4); set_bin(3,4,0,50,5);
    set_exp(3, 1'b0, 700, 10, -1, 1'b1);
    set_bin(4,0,200,1,1);   set_bin(4,1,300,2,2);   set_bin(4,2,400,3,3);  set_bin(4,3,500,4,4);  set_bin(4,4,950,77,-300);
    set_exp(4, 1'b1, 950, 77, -300, 1'b1);
    set_bin(5,0,599,11,1);  set_bin(5,1,600,12,2);  set_bin(5,2,0,13,3);   set_bin(5,3,600,14,4); set_bin(5,4,1,15,5);
    set_exp(5, 1'b1, 600, 12, 2, 1'b1);

    rst = 1'b1; run = 1'b0; abort = 1'b0; res_ready = 1'b1;
    corr_complete = 1'b0; search_complete = 1'b0;
    integrator = '0; code_phase = '0; doppler_omega = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ack_start", ack_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_peak", res_peak, 0);
    check("rst_sat_sel", sat_sel, 1);

    // Full sweep, ready tied high
    do_sweep(0, 0);
    // Ties, same-cycle bin + search_complete, threshold edge, backpressure on PRN 1
    do_sweep(3, 50);

    // Timeout on PRN 1
    res_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_ack("to_ack1", 4);
    t = 0;
    tick(); t++;
    corr_complete = 1'b1; integrator = 14'd800; code_phase = 10'd33; doppler_omega = 16'd44;
    tick(); t++;
    corr_complete = 1'b0;
    while (res_valid !== 1'b1 && t < 150) begin tick(); t++; end
    check("to_latency", t, 100);
    check("to_found", res_found, 0);
    check("to_peak", res_peak, 800);
    check("to_sat", res_sat, 1);
    check("to_err_set", timeout_err, 1);
    tick();

    // Sweep continues to PRN 2, then abort in its WAIT
    wait_ack("to_ack2", 4);
    check("to_err_sticky", timeout_err, 1);
    check("ab_sat_sel_2", sat_sel, 2);
    tick();
    corr_complete = 1'b1; integrator = 14'd900;
    tick();
    corr_complete = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_ack", ack_start, 0);
    check("ab_valid", res_valid, 0);
    check("ab_err_kept", timeout_err, 1);
    check("ab_sat_kept", sat_sel, 2);
    a0 = ack_cnt; d0 = done_cnt; v0 = valid_cyc;
    for (int k = 0; k < 20; k++) begin
      corr_complete   = (k == 5);
      search_complete = (k == 6);
      integrator      = 14'd1000;
      tick();
    end
    corr_complete = 1'b0; search_complete = 1'b0;
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_no_record", valid_cyc - v0, 0);
    check("idle_stray_no_ack", ack_cnt - a0, 0);
    check("idle_stray_busy", busy, 0);

    // Restart clears timeout_err and begins at PRN 1
    run = 1'b1;
    tick();
    run = 1'b0;
    check("rs_ack", ack_start, 1);
    check("rs_sat", sat_sel, 1);
    check("rs_err_clr", timeout_err, 0);
    check("rs_busy", busy, 1);
    d0 = done_cnt;
    run_prn(0, 1, 0, 1'b0);
    run_prn(1, 2, 0, 1'b1);
    wait_ack("rb_ack3", 10);
    check("rb_no_restart", sat_sel, 3);
    tick();
    corr_complete = 1'b1; integrator = 14'd650; code_phase = 10'd3; doppler_omega = 16'd3;
    search_complete = 1'b1;
    res_ready = 1'b0;
    tick();
    corr_complete = 1'b0; search_complete = 1'b0;
    wait_valid("rb_valid3", 4);
    check("rb_peak3", res_peak, 650);
    check("rb_found3", res_found, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", res_valid, 0);
    check("mr_sat", sat_sel, 1);
    check("mr_busy", busy, 0);
    check("mr_peak", res_peak, 0);
    repeat (4) tick();
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_idle_valid", res_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gps_ack_sched.md
Name: gps_ack_sched

Overview:
- Sequences the acquisition engine (gps_ack2-class datapath) across a range of satellite PRNs.
- Per PRN: fires ack_start, tracks the maximum integrator value reported on each corr_complete, and closes the PRN on search_complete.
- Emits one result record per PRN over a valid/ready handshake to the tracking-channel allocator.

Parameters:
- SAT_FIRST, 1, first PRN searched.
- SAT_LAST, 32, last PRN searched; SAT_LAST >= SAT_FIRST.
- INT_W, 14, integrator width.
- THRESH, 600, detection threshold; found when best peak >= THRESH.
- TIMEOUT, 4000000, clk cycles allowed per PRN between ack_start and search_complete.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  start a full sweep; level sampled in IDLE only.
- abort  in  1  terminate sweep; sampled in every state.
- busy  out  1  high in any state other than IDLE.
- sweep_done  out  1  one-cycle pulse after last PRN result is accepted.
- timeout_err  out  1  sticky; set on any PRN timeout; cleared by rst or by run accepted.
- ack_start  out  1  one-cycle start pulse to the engine.
- sat_sel  out  6  PRN currently under search.
- corr_complete  in  1  engine: one correlation bin done.
- integrator  in  INT_W  engine: unsigned magnitude for that bin.
- code_phase  in  10  engine: code phase of that bin.
- doppler_omega  in  16  engine: signed Doppler of that bin.
- search_complete  in  1  engine: all bins for sat_sel done.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts record.
- res_sat  out  6  PRN of record.
- res_peak  out  INT_W  best integrator value.
- res_code_phase  out  10  code phase at best peak.
- res_doppler  out  16  Doppler at best peak.
- res_found  out  1  res_peak >= THRESH and no timeout.

Behaviour:
- Reset: state IDLE. All outputs 0 (busy, sweep_done, timeout_err, ack_start, res_valid, res_*). sat_sel = SAT_FIRST. best registers 0. Timeout counter 0.
- FSM states: IDLE, START, WAIT, REPORT, NEXT, DONE.
- IDLE:
  - run=1 at an edge: enter START, sat_sel <= SAT_FIRST, timeout_err <= 0.
  - run while busy is ignored.
- START (exactly one cycle):
  - ack_start=1.
  - Clear best_peak/code/doppler to 0 and the timeout counter to 0.
  - Next state WAIT.
  - ack_start is high in the first cycle after the run-accepting edge.
- WAIT: timeout counter increments each cycle.
  - corr_complete=1 with integrator > best_peak (strict): capture integrator, code_phase, doppler_omega. Ties keep the earlier bin.
  - search_complete=1: go to REPORT. If corr_complete is also high in the same cycle, that bin is evaluated first and its capture appears in the record.
  - Counter reaches TIMEOUT-1 without search_complete: set timeout_err, go to REPORT with res_found forced 0.
- REPORT:
  - res_valid=1. Record is registered and held stable until res_valid && res_ready.
  - res_found = (best_peak >= THRESH) && !timed_out.
  - On handshake: res_valid drops next cycle, state NEXT. Zero-cycle wait is allowed when res_ready is already high.
- NEXT (one cycle):
  - sat_sel == SAT_LAST: go to DONE.
  - Otherwise sat_sel += 1 and go to START.
- DONE: sweep_done=1 for one cycle, then IDLE. busy falls in the IDLE cycle.
- sat_sel is stable from START through REPORT. It changes only in NEXT.
- corr_complete / search_complete outside WAIT are ignored and do not touch best registers.
- abort=1 in any state:
  - Next state IDLE.
  - res_valid and ack_start drop next cycle.
  - No sweep_done. timeout_err retained. sat_sel left at its current value.
  - abort wins over run and over any simultaneous handshake.
- rst mid-sweep returns every register to its reset value at the next edge.
- No arithmetic overflow: the comparison is unsigned INT_W. The counter width is clog2(TIMEOUT)+1.
- Cycle budget per PRN excluding the engine: START + NEXT + at least 1 REPORT = 3 cycles minimum.

Test Plan:
- Sweep SAT_FIRST=1, SAT_LAST=3, res_ready tied 1. Engine model gives 5 corr_completes per PRN, with PRN 2 peak 900 at code 512, doppler -40, others below 300. Expect 3 records in order 1,2,3. PRN2 res_found=1, peak 900, code 512, doppler -40. Others found=0. One sweep_done. Exactly 3 ack_start pulses.
- Tie and ordering: bins with integrator 700, 700 (code 10, then 20). Expect res_code_phase=10. corr_complete with 950 in the same cycle as search_complete: expect res_peak=950.
- Backpressure: hold res_ready=0 for 50 cycles in REPORT. Expect record fields constant, no next ack_start until 1 cycle after the handshake.
- Timeout with TIMEOUT=100 and the engine never asserting search_complete on PRN 1. Expect record at cycle 100 after ack_start with found=0, timeout_err=1 sticky, sweep continues to PRN 2.
- Abort in WAIT of PRN 2. Expect busy=0 next cycle, no sweep_done, no further records. A new run restarts at PRN 1 and clears timeout_err.
- run pulsed while busy, plus a stray corr_complete in IDLE. Expect no restart and best registers unchanged; a synchronous rst mid-REPORT clears res_valid and sat_sel to 1.
